// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the slave memory port.
// State encoding, latency counter width and slave ID width.
package slave_mem_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WR_WAIT = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int LAT_CNT_WIDTH = 4;
  localparam int ID_WIDTH      = 3;

  typedef enum logic [1:0] {
    IDLE    = S_IDLE,
    WR_WAIT = S_WR_WAIT,
    RD_WAIT = S_RD_WAIT,
    DONE    = S_DONE
  } state_t;

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port RAM, synchronous write and registered read.
// No reset on contents or read register so it maps to block RAM.
module sp_ram_sync #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/slave_mem_port.sv
// Memory-side consumer of the bus slave: RAM access plus fixed latency.
// Optional slave-ID address check: SLAVE_MEM_PORT_ID_CHECK_EN.
module slave_mem_port
  import slave_mem_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 15,
  parameter int          DATA_WIDTH     = 8,
  parameter int          MEM_ADDR_WIDTH = 12,
  parameter int          ACCESS_LATENCY = 4,
  parameter logic [2:0]  SELF_ID        = 3'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     write_en_internal,
  input  logic                     rd_req,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     module_dv,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     busy
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
  ,
  output logic                     addr_err
`endif
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [LAT_CNT_WIDTH-1:0] CNT_LOAD =
    LAT_CNT_WIDTH'(ACCESS_LATENCY - 1);

  state_t                   state;
  logic [LAT_CNT_WIDTH-1:0] cnt;
  logic                     err_q;
  logic                     bad;
  logic                     idle;
  logic                     ram_we;
  logic                     ram_re;
  logic [DATA_WIDTH-1:0]    ram_rdata;

`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
  localparam logic [ADDRESS_WIDTH-1:0] MID_MASK =
    (ADDRESS_WIDTH'(1) << (ADDRESS_WIDTH - ID_WIDTH)) -
    (ADDRESS_WIDTH'(1) << MEM_ADDR_WIDTH);

  assign bad = (addr_in[ADDRESS_WIDTH-1 -: ID_WIDTH] != SELF_ID) ||
               (|(addr_in & MID_MASK));
`else
  logic unused_bits;
  assign unused_bits = ^{addr_in[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH],
                         SELF_ID};
  assign bad = 1'b0;
`endif

  // Write lands at the acceptance edge; read data is parked in the RAM register.
  assign idle   = (state == IDLE) && rstn;
  assign ram_we = idle && write_en_internal && !bad;
  assign ram_re = idle && !write_en_internal && rd_req;

  sp_ram_sync #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_in[MEM_ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      module_dv <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
      addr_err  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (write_en_internal) begin
            state <= WR_WAIT;
            cnt   <= CNT_LOAD;
            err_q <= bad;
            busy  <= 1'b1;
          end else if (rd_req) begin
            state <= RD_WAIT;
            cnt   <= CNT_LOAD;
            err_q <= bad;
            busy  <= 1'b1;
          end
        end
        WR_WAIT, RD_WAIT: begin
          if (cnt == '0) begin
            state     <= DONE;
            module_dv <= 1'b1;
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
            addr_err  <= err_q;
`endif
            if (state == RD_WAIT)
              data_out <= err_q ? '1 : ram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          module_dv <= 1'b0;
          busy      <= 1'b0;
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
          addr_err  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_mem_port.sv
// Self-checking bench for slave_mem_port against a behavioural model.
// Honours SLAVE_MEM_PORT_ID_CHECK_EN (SELF_ID=3'b001 in that build).
module tb_slave_mem_port;

  localparam int LAT = 4;
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
  localparam logic [2:0] SID = 3'b001;
`else
  localparam logic [2:0] SID = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        write_en_internal = 1'b0;
  logic        rd_req = 1'b0;
  logic [14:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic        module_dv;
  logic [7:0]  data_out;
  logic        busy;
  logic        err_obs;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_m [int];
  logic [7:0] last_rd = 8'h00;

  always #5 clk = ~clk;

  slave_mem_port #(
    .ADDRESS_WIDTH  (15),
    .DATA_WIDTH     (8),
    .MEM_ADDR_WIDTH (12),
    .ACCESS_LATENCY (LAT),
    .SELF_ID        (SID)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .write_en_internal (write_en_internal),
    .rd_req            (rd_req),
    .addr_in           (addr_in),
    .data_in           (data_in),
    .module_dv         (module_dv),
    .data_out          (data_out),
    .busy              (busy)
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
    ,
    .addr_err          (err_obs)
`endif
  );

`ifndef SLAVE_MEM_PORT_ID_CHECK_EN
  assign err_obs = 1'b0;
`endif

  function automatic bit is_err(input logic [14:0] a);
`ifdef SLAVE_MEM_PORT_ID_CHECK_EN
    return (a >> 12) != 15'(SID);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request; checks every cycle from acceptance to one cycle past done.
  task automatic txn(input bit w, input bit r, input logic [14:0] a,
                     input logic [7:0] d, input int hold, input bit rpulse);
    bit e;
    e = is_err(a);
    if (w) begin
      if (!e) mem_m[int'(a % 4096)] = d;
    end else if (r) begin
      last_rd = e ? 8'hFF : mem_m[int'(a % 4096)];
    end
    @(negedge clk);
    write_en_internal = w;
    rd_req  = r;
    addr_in = a;
    data_in = d;
    @(posedge clk); #1;
    for (int k = 1; k <= LAT; k++) begin
      chk("busy_wait", 32'(busy), 32'd1);
      chk("dv_early", 32'(module_dv), 32'd0);
      @(negedge clk);
      write_en_internal = w && (k < hold);
      rd_req = rpulse && (k == 1);
      @(posedge clk); #1;
    end
    chk("dv_done", 32'(module_dv), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("data_done", 32'(data_out), 32'(last_rd));
    chk("err_done", 32'(err_obs), 32'(e));
    @(negedge clk);
    write_en_internal = 1'b0;
    rd_req = 1'b0;
    @(posedge clk); #1;
    chk("dv_after", 32'(module_dv), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("data_hold", 32'(data_out), 32'(last_rd));
    chk("err_after", 32'(err_obs), 32'd0);
  endtask

  initial begin
    logic [14:0] a;
    bit w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", 32'(module_dv), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    txn(1, 0, 15'h0012, 8'hA5, 1, 0);
    txn(0, 1, 15'h0012, 8'h00, 1, 0);
    txn(1, 1, 15'h0003, 8'h3C, 1, 0);
    txn(0, 1, 15'h0003, 8'h00, 1, 0);
    txn(1, 0, 15'h0040, 8'h5A, 2, 1);
    @(posedge clk); #1;
    chk("no_dup_dv", 32'(module_dv), 32'd0);
    chk("no_dup_busy", 32'(busy), 32'd0);
    txn(0, 1, 15'h0040, 8'h00, 1, 0);

    // Seed a pool of addresses so random reads never hit unwritten RAM.
    for (int i = 0; i < 8; i++)
      txn(1, 0, {SID, 12'(i * 37 + 5)}, 8'($urandom), 1, 0);
    for (int i = 0; i < 40; i++) begin
      a = {3'($urandom), 12'($urandom_range(0, 7) * 37 + 5)};
      if ($urandom_range(0, 2) == 0) a[14:12] = SID;
      w = $urandom_range(0, 1) == 1;
      txn(w, !w || ($urandom_range(0, 3) == 0), a, 8'($urandom), 1, 0);
    end

    // Reset two cycles into a read: no completion, output cleared.
    @(negedge clk);
    rd_req  = 1'b1;
    addr_in = 15'h0012;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_dv", 32'(module_dv), 32'd0);
    chk("rst_mid_data", 32'(data_out), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    last_rd = 8'h00;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      chk("rst_quiet_dv", 32'(module_dv), 32'd0);
    end
    txn(0, 1, {SID, 12'd5}, 8'h00, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slave_mem_port.md
Name: slave_mem_port

Overview:
- Memory-side consumer of the bus slave's internal interface.
- Accepts single-word write and read requests (local address + data) from the slave FSM and performs them on an internal synchronous RAM.
- Adds a fixed, programmable access latency, then returns a one-cycle `module_dv` strobe with read data. The slave's BUSY_WRT/BUSY_RD states wait on that strobe.
- One instance per slave node.

Parameters:
- ADDRESS_WIDTH, 15, full bus address width; top 3 bits are slave ID.
- DATA_WIDTH, 8, word width.
- MEM_ADDR_WIDTH, 12, local RAM address bits (RAM depth 2**MEM_ADDR_WIDTH); must be <= ADDRESS_WIDTH-3.
- ACCESS_LATENCY, 4, cycles from request acceptance to `module_dv`; legal range 1..15.
- SELF_ID, 3'b0, slave ID; used only by the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstn  in  1  synchronous active-low reset.
- write_en_internal  in  1  write request, level-sensitive; sampled only in IDLE.
- rd_req  in  1  read request, level-sensitive; sampled only in IDLE.
- addr_in  in  ADDRESS_WIDTH  bus address; low MEM_ADDR_WIDTH bits index RAM.
- data_in  in  DATA_WIDTH  write data.
- module_dv  out  1  one-cycle completion strobe (read or write).
- data_out  out  DATA_WIDTH  read data; valid while `module_dv`=1, held until next read completes.
- busy  out  1  high from acceptance until cycle after `module_dv`.

Behaviour:
- Clock/reset: one clock domain, `clk`. Reset is synchronous, active-low, on `rstn`.
- Reset values: `module_dv`=0, `data_out`=0, `busy`=0, state=IDLE, counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WR_WAIT, RD_WAIT, DONE.
- IDLE:
  - If `write_en_internal`=1: latch address/data, write RAM at this edge, load counter=ACCESS_LATENCY-1, go to WR_WAIT, `busy`=1.
  - Else if `rd_req`=1: latch address, issue RAM read, load counter, go to RD_WAIT, `busy`=1.
  - If both are high, the write wins; the read is dropped.
- WR_WAIT / RD_WAIT:
  - Decrement counter each cycle.
  - When counter==0: go to DONE and assert `module_dv` for exactly that one cycle.
  - For reads, `data_out` is loaded from RAM at the same edge.
  - Result: request sampled at edge N gives `module_dv` high during the cycle after edge N+ACCESS_LATENCY.
  - With ACCESS_LATENCY=1, the wait states are passed through in zero extra cycles.
- DONE:
  - `module_dv` returns to 0 and `busy` to 0; go to IDLE.
  - Requests are not sampled in DONE. Requests still high in IDLE start a new transaction; the slave holds `write_en_internal` for at most 2 cycles, so no duplicate occurs.
- Requests while not IDLE are ignored (no queue).
- Address: RAM index = `addr_in`[MEM_ADDR_WIDTH-1:0]; upper bits are ignored. Index wrap is natural modulo RAM depth.
- Reset mid-operation:
  - A write already accepted stays committed; the pending `module_dv` is cancelled.
  - A read is abandoned, with `data_out` forced to 0.
- Read-after-write to the same address returns the new data.

Optional Feature:
- Macro: SLAVE_MEM_PORT_ID_CHECK_EN.
- When defined:
  - Extra output `addr_err` (1 bit, reset 0).
  - On acceptance, if `addr_in`[ADDRESS_WIDTH-1:ADDRESS_WIDTH-3] != SELF_ID, or any bit between ID and MEM_ADDR_WIDTH is set:
    - the RAM is not written;
    - a read returns all-ones;
    - `addr_err` pulses together with `module_dv`.
  - Timing is unchanged.
- When undefined: no port and no check; upper address bits are fully ignored.

Decomposition:
- Package `slave_mem_pkg`:
  - state encoding localparams (IDLE=2'd0, WR_WAIT=2'd1, RD_WAIT=2'd2, DONE=2'd3);
  - LAT_CNT_WIDTH=4;
  - ID_WIDTH=3.
- Sub-module `sp_ram_sync`: single-port RAM with synchronous write and registered read, parameterised by depth and width. Inferable as block RAM.

Test Plan:
- Reset, then write 8'hA5 to addr 15'h0012 with ACCESS_LATENCY=4 -> `module_dv` one cycle, 4 cycles after request edge; `busy` high 5 cycles.
- Read addr 15'h0012 -> `module_dv` after 4 cycles with `data_out`=8'hA5; `data_out` holds 8'hA5 afterwards.
- `write_en_internal` and `rd_req` high together (addr 15'h0003, data 8'h3C) -> only the write executes; a later read of 15'h0003 returns 8'h3C.
- Write held 2 cycles, and a `rd_req` pulse during WR_WAIT -> exactly one `module_dv`; the read is ignored.
- `rstn`=0 two cycles after read acceptance -> no `module_dv`, `data_out`=0, `busy`=0 next cycle.
- With SLAVE_MEM_PORT_ID_CHECK_EN and SELF_ID=3'b001, write to 15'h0012 -> `addr_err`=1 with `module_dv`, RAM unchanged; read returns 8'hFF.
